trap_controller: RTL and testbench
==================================

# trap_controller

Sequences the RV32I pipeline on exceptional events flagged by the decode stage: illegal opcode, ECALL, EBREAK and MRET. It stalls fetch/decode, drains older instructions out of E/M/W, commits machine trap CSRs, then redirects fetch through a valid/ack handshake. It sits beside the hazard unit and drives the stall/flush lines with priority over it.

## Interface
- XLEN, 32, datapath width
- RESET_MTVEC, 32'h0000_0100, trap vector after reset
- DRAIN_CYCLES, 3, bubble cycles injected into E before commit (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_d  in  1  D stage holds a real instruction (not a bubble)
- illegal_d  in  1  IllegalOp from the main decoder
- ecall_d / ebreak_d / mret_d  in  1 each  decoded SYSTEM sub-ops in D
- pc_d  in  XLEN  PC of the D-stage instruction
- instr_d  in  32  raw D-stage instruction word
- csr_we  in  1  CSR write strobe from W stage
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  CSR write data
- redirect_ack  in  1  fetch accepted redirect_pc this cycle
- stall_f, stall_d  out  1  hold F and D
- flush_e  out  1  inject bubble into E
- flush_d  out  1  kill D contents
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  XLEN  new fetch address
- trap_busy  out  1  state ≠ IDLE
- mtvec, mepc, mcause, mtval  out  XLEN  CSR contents

## Operation
- trap_req = valid_d & (illegal_d | ecall_d | ebreak_d | mret_d); priority illegal > ecall > ebreak > mret.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE: trap_req → DRAIN, drain counter ← DRAIN_CYCLES; latch kind, pc_d, instr_d.
- DRAIN: counter decrements each cycle; at 1 → COMMIT.
- COMMIT: trap kinds write mepc ← {pc[31:2],2'b00}, mcause (illegal=2, ebreak=3, ecall=11), mtval (illegal: instr word; else 0); target ← mtvec. MRET writes no CSR; target ← mepc. → REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target held stable until redirect_ack; on the ack cycle flush_d=1, → IDLE.
- stall_f = stall_d = flush_e = trap_req (IDLE) or state ∈ {DRAIN, COMMIT, REDIRECT}; combinational so the trapping instruction never enters E.
- CSR port: 0x305 mtvec (bits[1:0] forced 0, direct mode), 0x341 mepc (bits[1:0] forced 0), 0x342 mcause, 0x343 mtval; other addresses ignored. Writes accepted in every state; during DRAIN they are from older instructions and must be visible to COMMIT (MRET returns to freshly written mepc).
- Simultaneous csr_we and COMMIT to the same CSR: COMMIT wins.
- trap_req while not IDLE: ignored (D is stalled; re-evaluated after redirect flushes it).

## Timing
- Reset: state IDLE, counter 0, mtvec=RESET_MTVEC, mepc=mcause=mtval=0; all control outputs 0, redirect_pc=0.
- Trap seen in IDLE at cycle T: DRAIN T+1..T+DRAIN_CYCLES, COMMIT T+DRAIN_CYCLES+1 (CSRs visible next cycle), redirect_valid from T+DRAIN_CYCLES+2.
- With redirect_ack tied high and defaults: redirect_valid only at T+5, IDLE at T+6.
- redirect_ack outside REDIRECT is ignored.
- rst mid-sequence: IDLE next edge, pending redirect dropped, CSRs return to reset values.

## Structure
- Package trap_pkg: state enum, cause constants (CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11), CSR address constants, trap-kind enum.
- One natural sub-module: trap_csr_regs (four CSRs, write port, commit-override priority); FSM and counter stay in trap_controller.

## Test plan
- illegal_d=1, pc_d=0x40, instr_d=0xFFFF_FFFF at T, ack tied 1 → redirect_pc=0x100 at T+5 only; mepc=0x40, mcause=2, mtval=0xFFFF_FFFF; stall_f high T..T+5.
- ecall_d at pc_d=0x80, ack delayed 3 cycles → redirect_valid/redirect_pc=0x100 held 4 cycles, flush_d only on ack cycle; mcause=11, mtval=0.
- csr_we to 0x341 with 0x200 during DRAIN, then mret → redirect_pc=0x200; mret with no trap pending leaves mcause unchanged.
- csr_we to 0x342 with 7 in the COMMIT cycle of an ebreak → mcause=3 (commit wins); write mtvec=0x303 → reads 0x300.
- illegal_d and ecall_d together → mcause=2; second trap_req during DRAIN ignored; valid_d=0 with illegal_d=1 → no action.
- rst asserted during REDIRECT → next cycle redirect_valid=0, trap_busy=0, mtvec=0x100, mepc=0.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller slice: FSM states,
// trap kinds, machine CSR addresses and exception cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        KIND_ILLEGAL,
        KIND_ECALL,
        KIND_EBREAK,
        KIND_MRET
    } trap_kind_t;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

    // MRET is not an exception, so it has no cause code.
    function automatic logic [31:0] cause_of(input trap_kind_t kind);
        logic [31:0] cause;
        cause = 32'd0;
        case (kind)
            KIND_ILLEGAL: cause = CAUSE_ILLEGAL;
            KIND_ECALL:   cause = CAUSE_ECALL_M;
            KIND_EBREAK:  cause = CAUSE_BREAKPOINT;
            default:      cause = 32'd0;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Machine trap CSRs (mtvec, mepc, mcause, mtval) with a software write port
// and a trap-commit port that overrides software writes in the same cycle.
module trap_csr_regs #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            commit_we,
    input  logic [XLEN-1:0] commit_mepc,
    input  logic [XLEN-1:0] commit_mcause,
    input  logic [XLEN-1:0] commit_mtval,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval
);
    import trap_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic sw_mtvec;
    logic sw_mepc;
    logic sw_mcause;
    logic sw_mtval;

    assign sw_mtvec  = csr_we && (csr_addr == CSR_MTVEC);
    assign sw_mepc   = csr_we && (csr_addr == CSR_MEPC);
    assign sw_mcause = csr_we && (csr_addr == CSR_MCAUSE);
    assign sw_mtval  = csr_we && (csr_addr == CSR_MTVAL);

    // mtvec is direct mode only, so the mode bits always read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec <= RESET_MTVEC;
        end else if (sw_mtvec) begin
            mtvec <= csr_wdata & ALIGN_MASK;
        end
    end

    // A committing trap writes all three registers, so it shadows any
    // software write to them in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (commit_we) begin
            mepc   <= commit_mepc & ALIGN_MASK;
            mcause <= commit_mcause;
            mtval  <= commit_mtval;
        end else begin
            if (sw_mepc) begin
                mepc <= csr_wdata & ALIGN_MASK;
            end
            if (sw_mcause) begin
                mcause <= csr_wdata;
            end
            if (sw_mtval) begin
                mtval <= csr_wdata;
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Pipeline trap sequencer: stalls F/D on an exceptional D-stage instruction,
// drains E/M/W, commits the trap CSRs and redirects fetch via valid/ack.
module trap_controller #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic            illegal_d,
    input  logic            ecall_d,
    input  logic            ebreak_d,
    input  logic            mret_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [31:0]     instr_d,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            redirect_ack,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_e,
    output logic            flush_d,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval
);
    import trap_pkg::*;

    localparam int               CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    trap_state_t     state;
    trap_state_t     state_next;
    trap_kind_t      req_kind;
    trap_kind_t      lat_kind;
    logic            trap_req;
    logic [CNT_W-1:0] drain_cnt;
    logic [XLEN-1:0] lat_pc;
    logic [31:0]     lat_instr;
    logic [XLEN-1:0] target;

    logic            commit_we;
    logic [XLEN-1:0] commit_mepc;
    logic [XLEN-1:0] commit_mcause;
    logic [XLEN-1:0] commit_mtval;

    assign trap_req = valid_d & (illegal_d | ecall_d | ebreak_d | mret_d);

    always_comb begin
        req_kind = KIND_MRET;
        if (illegal_d) begin
            req_kind = KIND_ILLEGAL;
        end else if (ecall_d) begin
            req_kind = KIND_ECALL;
        end else if (ebreak_d) begin
            req_kind = KIND_EBREAK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (trap_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == CNT_ONE) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The redirect target is captured in COMMIT so that CSR writes landing
    // during DRAIN (e.g. a fresh mepc before MRET) are honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            lat_kind  <= KIND_ILLEGAL;
            lat_pc    <= '0;
            lat_instr <= '0;
            target    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trap_req) begin
                        drain_cnt <= DRAIN_LOAD;
                        lat_kind  <= req_kind;
                        lat_pc    <= pc_d;
                        lat_instr <= instr_d;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_ONE;
                end
                ST_COMMIT: begin
                    target <= (lat_kind == KIND_MRET) ? mepc : mtvec;
                end
                default: begin
                end
            endcase
        end
    end

    assign commit_we     = (state == ST_COMMIT) && (lat_kind != KIND_MRET);
    assign commit_mepc   = lat_pc;
    assign commit_mcause = XLEN'(cause_of(lat_kind));
    assign commit_mtval  = (lat_kind == KIND_ILLEGAL) ? XLEN'(lat_instr) : '0;

    // Stalls are combinational on trap_req so the trapping instruction is
    // held in D on the very cycle it is decoded.
    always_comb begin
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        flush_e        = 1'b0;
        flush_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                stall_f = trap_req;
                stall_d = trap_req;
                flush_e = trap_req;
            end
            ST_DRAIN, ST_COMMIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            ST_REDIRECT: begin
                stall_f        = 1'b1;
                stall_d        = 1'b1;
                flush_e        = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target;
                flush_d        = redirect_ack;
            end
            default: begin
            end
        endcase
    end

    trap_csr_regs #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr_regs (
        .clk           (clk),
        .rst           (rst),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .commit_we     (commit_we),
        .commit_mepc   (commit_mepc),
        .commit_mcause (commit_mcause),
        .commit_mtval  (commit_mtval),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .mcause        (mcause),
        .mtval         (mtval)
    );

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: walks traps of each kind through
// drain/commit/redirect and checks outputs and CSRs against hand values.
module tb_trap_controller;

    logic        clk;
    logic        rst;
    logic        valid_d;
    logic        illegal_d;
    logic        ecall_d;
    logic        ebreak_d;
    logic        mret_d;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        redirect_ack;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_busy;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;

    int checks = 0;
    int errors = 0;

    trap_controller #(
        .XLEN         (32),
        .RESET_MTVEC  (32'h0000_0100),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_d        (valid_d),
        .illegal_d      (illegal_d),
        .ecall_d        (ecall_d),
        .ebreak_d       (ebreak_d),
        .mret_d         (mret_d),
        .pc_d           (pc_d),
        .instr_d        (instr_d),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .redirect_ack   (redirect_ack),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_e        (flush_e),
        .flush_d        (flush_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_busy      (trap_busy),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtval          (mtval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic v, input logic ill, input logic ec,
                                 input logic eb, input logic mr,
                                 input logic [31:0] pc, input logic [31:0] instr);
        valid_d   = v;
        illegal_d = ill;
        ecall_d   = ec;
        ebreak_d  = eb;
        mret_d    = mr;
        pc_d      = pc;
        instr_d   = instr;
    endtask

    task automatic setCsr(input logic we, input logic [11:0] addr, input logic [31:0] data);
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_ack = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        setCsr(0, 12'h000, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, trap_busy}, 32'h0);
        checkOutput("rst_stall", {29'b0, stall_f, stall_d, flush_e}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, redirect_valid}, 32'h0);
        checkOutput("rst_rpc", redirect_pc, 32'h0);
        checkOutput("rst_flush_d", {31'b0, flush_d}, 32'h0);
        checkOutput("rst_mtvec", mtvec, 32'h0000_0100);
        checkOutput("rst_mepc", mepc, 32'h0);
        checkOutput("rst_mcause", mcause, 32'h0);
        checkOutput("rst_mtval", mtval, 32'h0);
        rst = 1'b0;

        // Illegal instruction with ack tied high.
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 0, 32'h40, 32'hFFFF_FFFF);
        redirect_ack = 1'b1;
        #1;
        checkOutput("t1_stall_T", {29'b0, stall_f, stall_d, flush_e}, 32'h7);
        checkOutput("t1_busy_T", {31'b0, trap_busy}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
            #1;
            checkOutput($sformatf("t1_stall_T+%0d", i), {29'b0, stall_f, stall_d, flush_e}, 32'h7);
            checkOutput($sformatf("t1_rvalid_T+%0d", i), {31'b0, redirect_valid}, 32'h0);
        end
        @(negedge clk);
        #1;
        checkOutput("t1_rvalid_T+5", {31'b0, redirect_valid}, 32'h1);
        checkOutput("t1_rpc_T+5", redirect_pc, 32'h0000_0100);
        checkOutput("t1_flush_d_T+5", {31'b0, flush_d}, 32'h1);
        checkOutput("t1_stall_T+5", {29'b0, stall_f, stall_d, flush_e}, 32'h7);
        checkOutput("t1_mepc", mepc, 32'h40);
        checkOutput("t1_mcause", mcause, 32'd2);
        checkOutput("t1_mtval", mtval, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        checkOutput("t1_rvalid_T+6", {31'b0, redirect_valid}, 32'h0);
        checkOutput("t1_busy_T+6", {31'b0, trap_busy}, 32'h0);
        checkOutput("t1_stall_T+6", {29'b0, stall_f, stall_d, flush_e}, 32'h0);

        // ECALL with the ack delayed three cycles.
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 32'h80, 32'h0000_0073);
        redirect_ack = 1'b0;
        #1;
        checkOutput("t2_stall_T", {29'b0, stall_f, stall_d, flush_e}, 32'h7);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
            #1;
            checkOutput($sformatf("t2_busy_T+%0d", i), {31'b0, trap_busy}, 32'h1);
            checkOutput($sformatf("t2_rvalid_T+%0d", i), {31'b0, redirect_valid}, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("t2_rvalid_wait%0d", i), {31'b0, redirect_valid}, 32'h1);
            checkOutput($sformatf("t2_rpc_wait%0d", i), redirect_pc, 32'h0000_0100);
            checkOutput($sformatf("t2_flush_d_wait%0d", i), {31'b0, flush_d}, 32'h0);
        end
        @(negedge clk);
        redirect_ack = 1'b1;
        #1;
        checkOutput("t2_rvalid_ack", {31'b0, redirect_valid}, 32'h1);
        checkOutput("t2_rpc_ack", redirect_pc, 32'h0000_0100);
        checkOutput("t2_flush_d_ack", {31'b0, flush_d}, 32'h1);
        checkOutput("t2_mepc", mepc, 32'h80);
        checkOutput("t2_mcause", mcause, 32'd11);
        checkOutput("t2_mtval", mtval, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("t2_busy_after", {31'b0, trap_busy}, 32'h0);
        checkOutput("t2_rvalid_after", {31'b0, redirect_valid}, 32'h0);

        // MRET returning to an mepc written by an older instruction during DRAIN.
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 1, 32'h44, 32'h3020_0073);
        #1;
        checkOutput("t3_stall_T", {29'b0, stall_f, stall_d, flush_e}, 32'h7);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        setCsr(1, 12'h341, 32'h0000_0203);
        #1;
        checkOutput("t3_busy_drain", {31'b0, trap_busy}, 32'h1);
        @(negedge clk);
        setCsr(0, 12'h000, 32'h0);
        #1;
        checkOutput("t3_mepc_written", mepc, 32'h0000_0200);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("t3_rvalid", {31'b0, redirect_valid}, 32'h1);
        checkOutput("t3_rpc", redirect_pc, 32'h0000_0200);
        checkOutput("t3_mcause_kept", mcause, 32'd11);
        checkOutput("t3_mepc_kept", mepc, 32'h0000_0200);
        @(negedge clk);
        #1;
        checkOutput("t3_busy_after", {31'b0, trap_busy}, 32'h0);

        // EBREAK with a conflicting mcause write in its COMMIT cycle.
        @(negedge clk);
        applyStimulus(1, 0, 0, 1, 0, 32'h1C6, 32'h0010_0073);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        end
        @(negedge clk);
        setCsr(1, 12'h342, 32'd7);
        @(negedge clk);
        setCsr(0, 12'h000, 32'h0);
        #1;
        checkOutput("t4_rvalid", {31'b0, redirect_valid}, 32'h1);
        checkOutput("t4_rpc", redirect_pc, 32'h0000_0100);
        checkOutput("t4_mcause_commit_wins", mcause, 32'd3);
        checkOutput("t4_mepc_aligned", mepc, 32'h0000_01C4);
        checkOutput("t4_mtval", mtval, 32'h0);
        @(negedge clk);
        setCsr(1, 12'h305, 32'h0000_0303);
        #1;
        checkOutput("t4_busy_after", {31'b0, trap_busy}, 32'h0);
        @(negedge clk);
        setCsr(1, 12'h300, 32'hDEAD_0000);
        #1;
        checkOutput("t4_mtvec_aligned", mtvec, 32'h0000_0300);
        @(negedge clk);
        setCsr(1, 12'h343, 32'h0000_1234);
        #1;
        checkOutput("t4_mtvec_unmapped", mtvec, 32'h0000_0300);
        checkOutput("t4_mcause_unmapped", mcause, 32'd3);
        @(negedge clk);
        setCsr(0, 12'h000, 32'h0);
        #1;
        checkOutput("t4_mtval_sw", mtval, 32'h0000_1234);

        // Illegal and ECALL together; a second request during DRAIN is ignored.
        @(negedge clk);
        applyStimulus(1, 1, 1, 0, 0, 32'h50, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 32'h999, 32'h0000_0073);
        #1;
        checkOutput("t5_busy_drain", {31'b0, trap_busy}, 32'h1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("t5_rvalid_commit", {31'b0, redirect_valid}, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("t5_rvalid", {31'b0, redirect_valid}, 32'h1);
        checkOutput("t5_rpc", redirect_pc, 32'h0000_0300);
        checkOutput("t5_mcause", mcause, 32'd2);
        checkOutput("t5_mtval", mtval, 32'hDEAD_BEEF);
        checkOutput("t5_mepc", mepc, 32'h50);
        @(negedge clk);
        applyStimulus(0, 1, 0, 0, 0, 32'h60, 32'h0);
        #1;
        checkOutput("t5_bubble_stall", {29'b0, stall_f, stall_d, flush_e}, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        checkOutput("t5_bubble_busy", {31'b0, trap_busy}, 32'h0);
        checkOutput("t5_bubble_mtval", mtval, 32'hDEAD_BEEF);

        // Reset while a redirect is pending.
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 32'h90, 32'h0000_0073);
        redirect_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
        end
        @(negedge clk);
        #1;
        checkOutput("t6_rvalid_pre", {31'b0, redirect_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t6_rvalid", {31'b0, redirect_valid}, 32'h0);
        checkOutput("t6_busy", {31'b0, trap_busy}, 32'h0);
        checkOutput("t6_rpc", redirect_pc, 32'h0);
        checkOutput("t6_mtvec", mtvec, 32'h0000_0100);
        checkOutput("t6_mepc", mepc, 32'h0);
        checkOutput("t6_mcause", mcause, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
